piso_serializer: RTL and testbench

Parallel-in serial-out serializer that sits directly upstream of the team's SIPO deserializer. It accepts N-bit words over a valid/ready handshake and shifts each word out LSB-first, one bit per cycle. It also generates the enable and shift/capture control strobes the SIPO needs, so the SIPO reassembles each word unchanged. Throughput is one word per N+1 cycles with no bubble between back-to-back words.

---
 rtl/piso_serializer.sv | 142 ++++++++++++++
 tb/tb_piso_serializer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : piso_serializer
//  Purpose  : Parallel-in serial-out serializer. Accepts N-bit words over a
//             valid/ready handshake and shifts them out LSB-first. Also
//             generates the enable and shift/capture strobes for a
//             downstream SIPO, so that the SIPO rebuilds each word unchanged.
//             One word every N+1 cycles, with no gap between words.
//  Revision : 1.0  initial release
// ============================================================================
module piso_serializer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,        // synchronous, active-low
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         pause,
  output logic         ser_out,
  output logic         ser_en,
  output logic         ser_ctrl,
  output logic         done,
  output logic         busy,
  output logic [7:0]   word_cnt
);

  localparam int                   c_BCNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [c_BCNT_W-1:0]  c_LAST   = c_BCNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SHIFT   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [N-1:0]        r_sr;
  logic [N-1:0]        w_sr_nxt;
  logic [c_BCNT_W-1:0] r_bcnt;
  logic [c_BCNT_W-1:0] w_bcnt_nxt;
  logic                r_ser_out;
  logic                w_ser_out_nxt;
  logic                r_ser_ctrl;
  logic                r_done;
  logic [7:0]          r_word_cnt;
  logic                w_xfer;
  logic                w_enter_cap;

  // Handshake and strobe outputs decoded from the current state; pause
  // masks both so nothing moves upstream or downstream while stalled.
  assign in_ready = ((r_state == S_IDLE) || (r_state == S_CAPTURE)) && !pause;
  assign ser_en   = ((r_state == S_SHIFT) || (r_state == S_CAPTURE)) && !pause;
  assign busy     = (r_state != S_IDLE);
  assign w_xfer   = in_valid && in_ready;

  assign ser_out  = r_ser_out;
  assign ser_ctrl = r_ser_ctrl;
  assign done     = r_done;
  assign word_cnt = r_word_cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-datapath decode; everything holds unless a
  // transfer or an unpaused shift step says otherwise.
  always_comb begin
    w_state_nxt   = r_state;
    w_sr_nxt      = r_sr;
    w_bcnt_nxt    = r_bcnt;
    w_ser_out_nxt = r_ser_out;
    unique case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_state_nxt   = S_SHIFT;
          w_sr_nxt      = in_data;
          w_bcnt_nxt    = '0;
          w_ser_out_nxt = in_data[0];
        end
      end
      S_SHIFT: begin
        if (!pause) begin
          if (r_bcnt == c_LAST) begin
            w_state_nxt = S_CAPTURE;
          end else begin
            w_bcnt_nxt    = r_bcnt + 1'b1;
            w_sr_nxt      = r_sr >> 1;
            w_ser_out_nxt = r_sr[1];
          end
        end
      end
      S_CAPTURE: begin
        // A new word here chains straight into SHIFT with no idle cycle.
        if (w_xfer) begin
          w_state_nxt   = S_SHIFT;
          w_sr_nxt      = in_data;
          w_bcnt_nxt    = '0;
          w_ser_out_nxt = in_data[0];
        end else if (!pause) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Word completion is the SHIFT -> CAPTURE transition; a CAPTURE held by
  // pause is not a new completion.
  assign w_enter_cap = (w_state_nxt == S_CAPTURE) && (r_state == S_SHIFT);

  // Datapath and registered strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sr       <= '0;
      r_bcnt     <= '0;
      r_ser_out  <= 1'b0;
      r_ser_ctrl <= 1'b0;
      r_done     <= 1'b0;
      r_word_cnt <= 8'd0;
    end else begin
      r_sr       <= w_sr_nxt;
      r_bcnt     <= w_bcnt_nxt;
      r_ser_out  <= w_ser_out_nxt;
      r_ser_ctrl <= (w_state_nxt == S_CAPTURE);
      r_done     <= w_enter_cap;
      if (w_enter_cap) begin
        r_word_cnt <= r_word_cnt + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_piso_serializer
//  Purpose  : Self-checking bench for piso_serializer (N=4 and N=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       pause;
  logic       ser_out, ser_en, ser_ctrl, done, busy;
  logic [7:0] word_cnt;

  logic       v8;
  logic       rdy8;
  logic [7:0] d8;
  logic       p8;
  logic       so8, en8, ct8, dn8, bs8;
  logic [7:0] wc8;

  always #5 clk = ~clk;

  piso_serializer #(.N(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .pause(pause), .ser_out(ser_out), .ser_en(ser_en),
    .ser_ctrl(ser_ctrl), .done(done), .busy(busy), .word_cnt(word_cnt)
  );

  piso_serializer #(.N(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8),
    .in_data(d8), .pause(p8), .ser_out(so8), .ser_en(en8),
    .ser_ctrl(ct8), .done(dn8), .busy(bs8), .word_cnt(wc8)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Scoreboard: words pushed at the transfer, popped when the SIPO model captures.
  logic [3:0] sb_q[$];
  logic [3:0] sipo_f = 4'd0;
  int         cyc = 0;
  int         n_cap = 0;
  int         last_cap = 0;
  int         busy_cnt = 0;
  int         rdy_busy_cnt = 0;
  logic [7:0] cap_wc_prev = 8'd0;
  logic [7:0] cap_wc_last = 8'd0;

  always @(negedge clk) begin
    cyc++;
    if (rst === 1'b0) begin
      sb_q.delete();
    end else begin
      if (in_valid && in_ready) sb_q.push_back(in_data);
      if (busy) busy_cnt++;
      if (busy && in_ready) rdy_busy_cnt++;
      if (ser_en && !ser_ctrl) sipo_f = {ser_out, sipo_f[3:1]};
      if (ser_en && ser_ctrl) begin
        chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) chk("sipo_word", 32'(sipo_f), 32'(sb_q.pop_front()));
        n_cap++;
        last_cap    = cyc;
        cap_wc_prev = cap_wc_last;
        cap_wc_last = word_cnt;
      end
    end
  end

  // Table rows: inputs for a cycle and the outputs expected during it.
  typedef struct {
    logic       r, v;
    logic [3:0] d;
    logic       p, ck, cs, so, en, ct, dn, rd, bs;
    logic [7:0] wc;
  } vec_t;

  function automatic vec_t mk(logic r, logic v, logic [3:0] d, logic p, logic ck,
                              logic cs, logic so, logic en, logic ct, logic dn,
                              logic rd, logic bs, logic [7:0] wc);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.p = p; x.ck = ck; x.cs = cs; x.so = so;
    x.en = en; x.ct = ct; x.dn = dn; x.rd = rd; x.bs = bs; x.wc = wc;
    return x;
  endfunction

  vec_t tbl[$];

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; pause = 1'b0; v8 = 1'b0; p8 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic send4(input logic [3:0] w, input bit last);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    while (!in_ready && k < 64) begin
      k++;
      @(negedge clk);
    end
    chk("xfer_wait", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    if (last) in_valid = 1'b0;
  endtask

  task automatic wait_caps(input int target);
    int k;
    k = 0;
    while (n_cap < target && k < 3000) begin
      k++;
      @(posedge clk);
    end
    chk("cap_wait", 32'(n_cap >= target), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, b0, r0, c0;
    logic [7:0] w8;
    rst = 1'b0; in_valid = 1'b0; in_data = 4'd0; pause = 1'b0;
    v8 = 1'b0; d8 = 8'd0; p8 = 1'b0;

    //            r  v  d     p  ck cs so en ct dn rd bs wc
    tbl.push_back(mk(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0));
    tbl.push_back(mk(1, 0, 4'h0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 8'd0)); // reset state, paused
    tbl.push_back(mk(1, 1, 4'hB, 0, 1, 0, 0, 0, 0, 0, 1, 0, 8'd0)); // send 1011
    tbl.push_back(mk(1, 0, 4'h0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 8'd0));
    tbl.push_back(mk(1, 0, 4'h0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 8'd0));
    tbl.push_back(mk(1, 0, 4'h0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 8'd0));
    tbl.push_back(mk(1, 0, 4'h0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 8'd0));
    tbl.push_back(mk(1, 0, 4'h0, 0, 1, 0, 0, 1, 1, 1, 1, 1, 8'd1)); // capture
    tbl.push_back(mk(1, 0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 8'd1));
    tbl.push_back(mk(1, 1, 4'h6, 0, 1, 0, 0, 0, 0, 0, 1, 0, 8'd1)); // send 0110
    tbl.push_back(mk(1, 0, 4'hF, 0, 1, 1, 0, 1, 0, 0, 0, 1, 8'd1));
    tbl.push_back(mk(1, 0, 4'hF, 0, 1, 1, 1, 1, 0, 0, 0, 1, 8'd1));
    tbl.push_back(mk(1, 1, 4'hF, 1, 1, 1, 1, 0, 0, 0, 0, 1, 8'd1)); // pause x3
    tbl.push_back(mk(1, 1, 4'hF, 1, 1, 1, 1, 0, 0, 0, 0, 1, 8'd1));
    tbl.push_back(mk(1, 1, 4'hF, 1, 1, 1, 1, 0, 0, 0, 0, 1, 8'd1));
    tbl.push_back(mk(1, 0, 4'h0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 8'd1));
    tbl.push_back(mk(1, 0, 4'h0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 8'd1));
    tbl.push_back(mk(1, 0, 4'h0, 0, 1, 0, 0, 1, 1, 1, 1, 1, 8'd2)); // delayed capture
    tbl.push_back(mk(1, 1, 4'h9, 0, 1, 0, 0, 0, 0, 0, 1, 0, 8'd2)); // send 1001
    tbl.push_back(mk(1, 0, 4'h0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 8'd2));
    tbl.push_back(mk(1, 0, 4'h0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 8'd2));
    tbl.push_back(mk(1, 0, 4'h0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 8'd2));
    tbl.push_back(mk(1, 0, 4'h0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 8'd2));
    tbl.push_back(mk(1, 1, 4'h3, 1, 1, 0, 0, 0, 1, 1, 0, 1, 8'd3)); // capture paused
    tbl.push_back(mk(1, 1, 4'h3, 1, 1, 0, 0, 0, 1, 0, 0, 1, 8'd3));
    tbl.push_back(mk(1, 0, 4'h0, 0, 1, 0, 0, 1, 1, 0, 1, 1, 8'd3)); // released
    tbl.push_back(mk(1, 0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 8'd3));
    tbl.push_back(mk(1, 1, 4'hC, 0, 1, 0, 0, 0, 0, 0, 1, 0, 8'd3)); // send 1100
    tbl.push_back(mk(1, 0, 4'h0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 8'd3));
    tbl.push_back(mk(0, 0, 4'h0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 8'd3)); // reset mid-word
    tbl.push_back(mk(1, 0, 4'h0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 8'd0));
    tbl.push_back(mk(1, 1, 4'h5, 0, 1, 0, 0, 0, 0, 0, 1, 0, 8'd0)); // send 0101
    tbl.push_back(mk(1, 0, 4'h0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 8'd0));
    tbl.push_back(mk(1, 0, 4'h0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 8'd0));
    tbl.push_back(mk(1, 0, 4'h0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 8'd0));
    tbl.push_back(mk(1, 0, 4'h0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 8'd0));
    tbl.push_back(mk(1, 0, 4'h0, 0, 1, 0, 0, 1, 1, 1, 1, 1, 8'd1));
    tbl.push_back(mk(1, 0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 8'd1));

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      rst = tbl[i].r; in_valid = tbl[i].v; in_data = tbl[i].d; pause = tbl[i].p;
      @(negedge clk);
      if (tbl[i].ck)
        chk($sformatf("row%0d_ctrl", i),
            32'({ser_en, ser_ctrl, done, in_ready, busy, word_cnt}),
            32'({tbl[i].en, tbl[i].ct, tbl[i].dn, tbl[i].rd, tbl[i].bs, tbl[i].wc}));
      if (tbl[i].cs)
        chk($sformatf("row%0d_ser_out", i), 32'(ser_out), 32'(tbl[i].so));
    end

    // Back-to-back A, 5, F with in_valid held.
    do_reset();
    b0 = busy_cnt; r0 = rdy_busy_cnt; c0 = n_cap;
    send4(4'hA, 1'b0);
    t0 = cyc;
    send4(4'h5, 1'b0);
    send4(4'hF, 1'b1);
    wait_caps(c0 + 3);
    chk("b2b_span", 32'(last_cap - t0), 32'd15);
    chk("b2b_busy_cycles", 32'(busy_cnt - b0), 32'd15);
    chk("b2b_ready_while_busy", 32'(rdy_busy_cnt - r0), 32'd3);
    chk("b2b_word_cnt", 32'(word_cnt), 32'd3);

    // 256 words: counter wraps on the last capture.
    do_reset();
    c0 = n_cap;
    for (int i = 0; i < 256; i++) send4(4'(i * 7 + 3), i == 255);
    wait_caps(c0 + 256);
    chk("wrap_cnt_255", 32'(cap_wc_prev), 32'd255);
    chk("wrap_cnt_0", 32'(cap_wc_last), 32'd0);
    chk("wrap_word_cnt", 32'(word_cnt), 32'd0);

    // N=8: 8'hC3 LSB-first, capture at t+9.
    do_reset();
    w8 = 8'hC3;
    v8 = 1'b1; d8 = w8;
    @(negedge clk);
    chk("n8_ready", 32'(rdy8), 32'd1);
    @(posedge clk); #1;
    v8 = 1'b0; d8 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("n8_bit%0d", i), 32'({so8, en8, ct8}), 32'({w8[i], 1'b1, 1'b0}));
    end
    @(negedge clk);
    chk("n8_capture", 32'({en8, ct8, dn8, wc8}), 32'({1'b1, 1'b1, 1'b1, 8'd1}));
    @(negedge clk);
    chk("n8_idle", 32'({bs8, en8, rdy8}), 32'({1'b0, 1'b0, 1'b1}));

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
